// File: rtl/addsub_sequencer.sv
// Request/response sequencer around an external 8-bit adder-subtractor:
// registers operands on accept, captures the result one cycle later into a show-ahead FIFO.
module addsub_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_A,
    input  logic [7:0] in_B,
    input  logic       in_Mode,
    input  logic       in_Acc,
    output logic [7:0] add_A,
    output logic [7:0] add_B,
    output logic       add_Mode,
    input  logic [7:0] add_S,
    input  logic       add_Carry,
    input  logic       add_Overflow,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_S,
    output logic       out_Carry,
    output logic       out_Overflow,
    output logic       out_Zero,
    output logic       out_Neg,
    output logic [7:0] acc,
    output logic [7:0] ovf_count,
    input  logic       ovf_clr
);

    localparam int DATA_W  = 8;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = DATA_W + 2;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   add_a_q, add_a_d;
    logic [DATA_W-1:0]   add_b_q, add_b_d;
    logic                add_mode_q, add_mode_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   ovf_q, ovf_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ENTRY_W-1:0]  mem_q [DEPTH];

    logic                accept;
    logic                push;
    logic                pop;
    logic [ENTRY_W-1:0]  head;
    logic [DATA_W-1:0]   head_s;

    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
        return (v == '1) ? v : v + DATA_W'(1);
    endfunction

    assign in_ready = (state_q == IDLE) && (count_q < DEPTH_C);
    assign accept   = in_valid && in_ready;
    assign out_valid = (count_q != '0);
    assign pop      = out_valid && out_ready;

    always_comb begin
        state_d    = state_q;
        add_a_d    = add_a_q;
        add_b_d    = add_b_q;
        add_mode_d = add_mode_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        push       = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    add_a_d    = in_Acc ? acc_q : in_A;
                    add_b_d    = in_B;
                    add_mode_d = in_Mode;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                // Space for this push was reserved when the request was accepted.
                push    = 1'b1;
                acc_d   = add_S;
                if (add_Overflow) begin
                    ovf_d = sat_inc(ovf_q);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (ovf_clr) begin
            ovf_d = '0;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= IDLE;
            add_a_q    <= '0;
            add_b_q    <= '0;
            add_mode_q <= 1'b0;
            acc_q      <= '0;
            ovf_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            add_a_q    <= add_a_d;
            add_b_q    <= add_b_d;
            add_mode_q <= add_mode_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: every read is qualified by a non-zero count.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {add_S, add_Carry, add_Overflow};
        end
    end

    assign head   = mem_q[rd_ptr_q];
    assign head_s = head[ENTRY_W-1:2];

    assign out_S        = out_valid ? head_s : '0;
    assign out_Carry    = out_valid && head[1];
    assign out_Overflow = out_valid && head[0];
    assign out_Zero     = out_valid && (head_s == '0);
    assign out_Neg      = out_valid && head_s[DATA_W-1];

    assign add_A     = add_a_q;
    assign add_B     = add_b_q;
    assign add_Mode  = add_mode_q;
    assign acc       = acc_q;
    assign ovf_count = ovf_q;

endmodule
